// File: rtl/display_pkg.sv
// Shared types and glyph helpers for the 7-segment display driver.
// Glyphs are active low in {g,f,e,d,c,b,a} order.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble: 8-bit (optionally signed) value to sign + 3 BCD digits.
// start is taken only in IDLE; results appear 10 cycles after the start cycle.
module bin_to_bcd_seq
    import display_pkg::*;
#(
    parameter int CONV_ITER = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  din,
    input  logic        is_signed,
    output logic        busy,
    output logic        done,
    output logic        neg,
    output logic [11:0] bcd
);

    localparam int CNT_W = $clog2(CONV_ITER + 1);

    conv_state_t        state;
    logic [CNT_W-1:0]   cnt;
    logic [7:0]         mag;
    logic [11:0]        scratch;
    logic [11:0]        adj;
    logic               neg_s;

    always_comb begin
        adj = scratch;
        for (int i = 0; i < 3; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            mag     <= '0;
            scratch <= '0;
            neg_s   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            neg     <= 1'b0;
            bcd     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // Negating 8'h80 wraps to 8'h80, read unsigned as 128.
                    if (is_signed && din[7]) begin
                        mag   <= 8'(~din + 8'd1);
                        neg_s <= 1'b1;
                    end else begin
                        mag   <= din;
                        neg_s <= 1'b0;
                    end
                    scratch <= '0;
                    cnt     <= '0;
                    state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    {scratch, mag} <= {adj[10:0], mag, 1'b0};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(CONV_ITER - 1)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    bcd   <= scratch;
                    neg   <= neg_s;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/out_display_driver.sv
// Drives a 4-digit common-anode multiplexed display from the processor output terminal.
// Decimal (signed/unsigned) via a sequential converter, or live hex; glyphs latch per scan slot.
module out_display_driver
    import display_pkg::*;
#(
    parameter int REFRESH_BITS = 16,
    parameter int CONV_ITER    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    input  logic       signed_mode,
    input  logic       hex_mode,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy
);

    logic [7:0]              cap_val;
    logic                    cap_mode;
    logic                    pending;
    logic                    start;
    logic                    conv_done;
    logic                    neg;
    logic [11:0]             bcd;
    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic [1:0]              sel;
    logic [1:0]              sel_nxt;
    logic [6:0]              glyph [4];

    assign dp = 1'b1;

    // busy is low only while the converter sits in IDLE.
    assign start = !busy && (pending || (value != cap_val) || (signed_mode != cap_mode));

    bin_to_bcd_seq #(
        .CONV_ITER(CONV_ITER)
    ) u_conv (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .din      (cap_val),
        .is_signed(cap_mode),
        .busy     (busy),
        .done     (conv_done),
        .neg      (neg),
        .bcd      (bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_val  <= '0;
            cap_mode <= 1'b0;
            pending  <= 1'b1;
        end else begin
            if (start) begin
                cap_val  <= value;
                cap_mode <= signed_mode;
            end
            if (conv_done) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            glyph[i] = SEG_BLANK;
        end
        if (hex_mode) begin
            glyph[1] = hex_to_seg(value[7:4]);
            glyph[0] = hex_to_seg(value[3:0]);
        end else begin
            glyph[3] = neg ? SEG_MINUS : SEG_BLANK;
            glyph[2] = (bcd[11:8] != 4'd0) ? hex_to_seg(bcd[11:8]) : SEG_BLANK;
            glyph[1] = (bcd[11:4] != 8'd0) ? hex_to_seg(bcd[7:4]) : SEG_BLANK;
            glyph[0] = hex_to_seg(bcd[3:0]);
        end
    end

    assign sel_nxt = sel + 2'd1;

    // an and seg are loaded together at each slot boundary so a digit never
    // shows a glyph that changed part way through its slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            sel         <= '0;
            an          <= 4'b1111;
            seg         <= SEG_BLANK;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
            if (refresh_cnt == {REFRESH_BITS{1'b1}}) begin
                sel <= sel_nxt;
                an  <= ~(4'b0001 << sel_nxt);
                seg <= glyph[sel_nxt];
            end
        end
    end

endmodule

// File: tb/tb_out_display_driver.sv
// Scoreboard bench for out_display_driver: conversions checked as busy falls,
// scanned glyphs checked per digit once the display has settled.
module tb_out_display_driver;

    typedef struct {
        logic        neg;
        logic [11:0] bcd;
    } conv_t;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] MINUS = 7'h3F;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] value;
    logic       signed_mode;
    logic       hex_mode;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;
    int conv_cnt    = 0;
    int busy_len    = 0;
    logic busy_q    = 1'b0;
    conv_t sb [$];

    out_display_driver #(
        .REFRESH_BITS(2),
        .CONV_ITER   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .signed_mode(signed_mode),
        .hex_mode   (hex_mode),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic conv_t model_conv(input logic [7:0] v, input logic sm);
        conv_t r;
        int    mag;
        r.neg = sm && v[7];
        mag   = r.neg ? 256 - int'(v) : int'(v);
        r.bcd = {4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)};
        return r;
    endfunction

    function automatic logic [27:0] model_disp(input logic [7:0] v, input logic sm, input logic hm);
        conv_t c;
        logic [6:0] d3, d2, d1, d0;
        if (hm) begin
            d3 = BLANK;
            d2 = BLANK;
            d1 = GLYPH[v[7:4]];
            d0 = GLYPH[v[3:0]];
        end else begin
            c  = model_conv(v, sm);
            d3 = c.neg ? MINUS : BLANK;
            d2 = (c.bcd[11:8] != 0) ? GLYPH[c.bcd[11:8]] : BLANK;
            d1 = (c.bcd[11:4] != 0) ? GLYPH[c.bcd[7:4]] : BLANK;
            d0 = GLYPH[c.bcd[3:0]];
        end
        return {d3, d2, d1, d0};
    endfunction

    // Every busy pulse must last 10 cycles and end with the expected result.
    always @(negedge clk) begin
        if (rst) begin
            busy_len = 0;
            busy_q   = 1'b0;
        end else begin
            if (busy) begin
                busy_len++;
            end else if (busy_q) begin
                check("busy_len", busy_len, 10);
                if (sb.size() == 0) begin
                    check("sb_underflow", sb.size(), 1);
                end else begin
                    conv_t e;
                    e = sb.pop_front();
                    check("bcd", dut.u_conv.bcd, e.bcd);
                    check("neg", dut.u_conv.neg, e.neg);
                end
                conv_cnt++;
                busy_len = 0;
            end
            busy_q = busy;
        end
    end

    task automatic drive(input logic [7:0] v, input logic sm, input logic hm);
        @(posedge clk);
        #1;
        value       = v;
        signed_mode = sm;
        hex_mode    = hm;
    endtask

    task automatic wait_conv(input int target);
        for (int i = 0; i < 200 && conv_cnt < target; i++) @(posedge clk);
        check("conv_timeout", conv_cnt, target);
    endtask

    task automatic scan_check(input string tag, input logic [27:0] exp);
        logic [6:0] obs [4];
        for (int i = 0; i < 4; i++) obs[i] = 'x;
        repeat (20) @(posedge clk);
        repeat (20) begin
            @(negedge clk);
            case (an)
                4'b1110: obs[0] = seg;
                4'b1101: obs[1] = seg;
                4'b1011: obs[2] = seg;
                4'b0111: obs[3] = seg;
                default: check({tag, "_an"}, an, 4'b1110);
            endcase
        end
        check({tag, "_d0"}, obs[0], exp[6:0]);
        check({tag, "_d1"}, obs[1], exp[13:7]);
        check({tag, "_d2"}, obs[2], exp[20:14]);
        check({tag, "_d3"}, obs[3], exp[27:21]);
        check({tag, "_dp"}, dp, 1);
    endtask

    initial begin
        int base;
        int busy_seen;
        rst         = 1'b1;
        value       = 8'd0;
        signed_mode = 1'b0;
        hex_mode    = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_an", an, 4'b1111);
            check("rst_seg", seg, 7'h7F);
            check("rst_busy", busy, 0);
            check("rst_dp", dp, 1);
        end
        sb.push_back(model_conv(8'd0, 1'b0));
        @(posedge clk);
        #1 rst = 1'b0;
        wait_conv(1);
        scan_check("zero", model_disp(8'd0, 1'b0, 1'b0));

        drive(8'd200, 1'b0, 1'b0);
        sb.push_back(model_conv(8'd200, 1'b0));
        wait_conv(2);
        scan_check("u200", model_disp(8'd200, 1'b0, 1'b0));

        drive(8'hF6, 1'b1, 1'b0);
        sb.push_back(model_conv(8'hF6, 1'b1));
        wait_conv(3);
        scan_check("sm10", model_disp(8'hF6, 1'b1, 1'b0));

        drive(8'h80, 1'b1, 1'b0);
        sb.push_back(model_conv(8'h80, 1'b1));
        wait_conv(4);
        scan_check("sm128", model_disp(8'h80, 1'b1, 1'b0));

        drive(8'h80, 1'b0, 1'b0);
        sb.push_back(model_conv(8'h80, 1'b0));
        wait_conv(5);
        scan_check("u128", model_disp(8'h80, 1'b0, 1'b0));

        // Change the input on the third SHIFT cycle of a running conversion.
        drive(8'd5, 1'b0, 1'b0);
        sb.push_back(model_conv(8'd5, 1'b0));
        for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
        repeat (3) @(posedge clk);
        #1 value = 8'd99;
        sb.push_back(model_conv(8'd99, 1'b0));
        wait_conv(7);
        scan_check("u99", model_disp(8'd99, 1'b0, 1'b0));

        drive(8'hAB, 1'b0, 1'b0);
        sb.push_back(model_conv(8'hAB, 1'b0));
        wait_conv(8);
        scan_check("u171", model_disp(8'hAB, 1'b0, 1'b0));

        base      = conv_cnt;
        busy_seen = 0;
        drive(8'hAB, 1'b0, 1'b1);
        fork
            scan_check("hexab", model_disp(8'hAB, 1'b0, 1'b1));
            repeat (40) begin
                @(negedge clk);
                if (busy) busy_seen = 1;
            end
        join
        check("hex_busy", busy_seen, 0);
        check("hex_no_conv", conv_cnt, base);

        drive(8'hAB, 1'b0, 1'b0);
        scan_check("back171", model_disp(8'hAB, 1'b0, 1'b0));
        check("no_conv_back", conv_cnt, base);
        check("sb_left", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/out_display_driver.md
Name: out_display_driver

Overview:
- Downstream consumer of the processor's 8-bit output terminal. Drives a 4-digit, common-anode, multiplexed 7-segment display.
- A sequential double-dabble engine converts the terminal value to decimal, as signed or unsigned. A hex mode bypasses the conversion.
- Sits at board top level between the processor core's `out` and the display pins, in the same clock domain as the core.

Parameters:
- REFRESH_BITS, 16, width of the refresh counter; the active digit advances once per 2^REFRESH_BITS clocks.
- CONV_ITER, 8, number of double-dabble shift iterations; equals the input width and is not to be changed.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- value  in  8  processor output terminal value.
- signed_mode  in  1  1 = interpret value as two's complement.
- hex_mode  in  1  1 = display two hex digits; no conversion used.
- an  out  4  digit anodes, active low, one-hot; an[0] is the rightmost digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active low.
- dp  out  1  decimal point, active low; tied to 1 (off).
- busy  out  1  1 while a conversion is in progress.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset state:
  - an=4'b1111, seg=7'h7F, dp=1, busy=0.
  - Captured value, captured mode and BCD digits cleared to 0; refresh counter 0; digit select 0.
  - A `pending` flag is set so a conversion runs immediately after reset.
- Change detect (in IDLE only): start a conversion when `pending` is set, or value differs from the captured value, or signed_mode differs from the captured mode. Capture value and mode on that edge.
- FSM states: IDLE -> LOAD -> SHIFT (exactly 8 cycles) -> DONE -> IDLE.
  - LOAD: form the magnitude. If signed_mode=1 and value[7]=1, magnitude = (~value + 1) as 8-bit unsigned, so 8'h80 gives 128; set neg=1. Otherwise magnitude = value and neg=0. Clear the 12-bit BCD scratch.
  - SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, mag} left by 1.
  - DONE: copy scratch to the displayed hundreds/tens/units and neg registers; clear `pending`.
  - busy=1 in LOAD, SHIFT and DONE.
  - Latency: displayed digits update exactly 10 cycles after the IDLE cycle that detected the change.
- Input changes while busy: ignored until the FSM returns to IDLE, then re-detected. The final display always reflects the latest stable value.
- Rst asserted mid-conversion: aborts to IDLE with the reset values above, then reconverts (`pending`=1).
- Refresh:
  - The counter increments every clock; on wrap, digit select advances 0->1->2->3->0.
  - an = ~(4'b0001 << sel), registered; seg is registered in the same cycle as an.
- Decimal mode glyphs (hex_mode=0):
  - digit3 = minus (7'b0111111) if neg, else blank.
  - digit2 = hundreds, blank if 0.
  - digit1 = tens, blank if hundreds and tens are both 0.
  - digit0 = units, always shown.
- Hex mode glyphs (hex_mode=1): digit1 = value[7:4], digit0 = value[3:0], read live from value; digits 3 and 2 blank. hex_mode is display-only and does not trigger a conversion.
- Glyph encodings:
  - Blank = 7'h7F.
  - Hex glyph set 0-F uses lowercase b and d.
  - Glyph changes on a digit take effect at that digit's next scan slot.

Decomposition:
- Shared package `display_pkg`:
  - FSM state enum (IDLE, LOAD, SHIFT, DONE).
  - SEG_BLANK and SEG_MINUS constants.
  - `hex_to_seg` function (4-bit -> 7-bit, active low).
- Sub-module `bin_to_bcd_seq`:
  - Contains the FSM, the shift counter and the BCD datapath.
  - Ports: clk, rst, start, din[7:0], is_signed, busy, done, neg, bcd[11:0].
- The top holds change detect, the refresh counter and glyph selection.

Test Plan:
- Reset with value=0, REFRESH_BITS=2 -> an=1111 and seg=7F during reset; busy high for 10 cycles after release; then in the slot with an=1110, seg=7'b1000000 ("0"); all other slots 7F.
- value=8'd200, signed_mode=0 -> after exactly 10 cycles, BCD digits = 2,0,0; scan shows digit2 = 7'b0100100, digit1 and digit0 = 7'b1000000, digit3 blank.
- value=8'hF6, signed_mode=1 -> display "-10": digit3 = 7'b0111111, digit2 blank, digit1 = 7'b1111001, digit0 = 7'b1000000.
- value=8'h80, signed_mode=1 -> "-128". The same value with signed_mode=0 -> "128" with digit3 blank; the mode toggle alone triggers a reconversion.
- value changes 8'd5 -> 8'd99 on the 3rd SHIFT cycle -> first conversion completes showing "5", busy stays high for a second 10-cycle conversion, final display "99".
- hex_mode=1, value=8'hAB -> digit1 = 7'b0001000 ("A"), digit0 = 7'b0000011 ("b"), digits 3 and 2 = 7F. busy stays 0 when only hex_mode toggles.
